// File: rtl/ahb_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_if
// Brief    : AHB-Lite slave front end for the two-bank, eight-byte-lane SRAM
//            core. Optional macro AHB_SRAM_ERR_RESP_EN adds the two-cycle
//            ERROR response for illegal size/alignment combinations.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_if (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hready_out,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata,
   input  logic [7:0]  sram_q0,
   input  logic [7:0]  sram_q1,
   input  logic [7:0]  sram_q2,
   input  logic [7:0]  sram_q3,
   input  logic [7:0]  sram_q4,
   input  logic [7:0]  sram_q5,
   input  logic [7:0]  sram_q6,
   input  logic [7:0]  sram_q7,
   output logic        sram_wen,
   output logic [12:0] sram_addr,
   output logic [31:0] sram_wdata,
   output logic        bank_sel,
   output logic [3:0]  bank0_csn,
   output logic [3:0]  bank1_csn
);

   localparam logic [3:0] c_CSN_NONE   = 4'b1111;
   localparam logic [3:0] c_CSN_ALL    = 4'b0000;
   localparam logic [1:0] c_RESP_OKAY  = 2'b00;
`ifdef AHB_SRAM_ERR_RESP_EN
   localparam logic [1:0] c_RESP_ERROR = 2'b01;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD1  = 3'd2,
      S_RD2  = 3'd3
`ifdef AHB_SRAM_ERR_RESP_EN
      ,
      S_ERR1 = 3'd4,
      S_ERR2 = 3'd5
`endif
   } state_t;

   state_t      r_state;
   logic [15:2] r_addr;

   logic        w_valid;
   logic        w_accept;
   logic        w_illegal;
   logic [3:0]  w_lane_mask;
   logic        w_unused_bits;

   assign w_valid   = hsel & hready & htrans[1];
   assign w_accept  = w_valid & ((r_state == S_IDLE) | (r_state == S_WR) | (r_state == S_RD2));
   assign w_illegal = (hsize > 3'd2)
                    | ((hsize == 3'd1) & haddr[0])
                    | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));

   // Only the low 64 KiB is decoded; SEQ and NONSEQ are treated alike.
   assign w_unused_bits = &{1'b0, haddr[31:16], htrans[0]};

   // Active-low byte lanes touched by a legal write, from the address-phase controls.
   always_comb begin
      w_lane_mask = c_CSN_ALL;
      case (hsize[1:0])
         2'd0:    w_lane_mask = ~(4'b0001 << haddr[1:0]);
         2'd1:    w_lane_mask = haddr[1] ? 4'b0011 : 4'b1100;
         default: w_lane_mask = c_CSN_ALL;
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         hready_out <= 1'b1;
         hresp      <= c_RESP_OKAY;
         sram_wen   <= 1'b1;
         bank0_csn  <= c_CSN_NONE;
         bank1_csn  <= c_CSN_NONE;
      end else begin
         if (w_accept) begin
            r_addr <= haddr[15:2];
         end
         case (r_state)
            S_RD1: begin
               r_state    <= S_RD2;
               hready_out <= 1'b1;
               hresp      <= c_RESP_OKAY;
               sram_wen   <= 1'b1;
               bank0_csn  <= c_CSN_NONE;
               bank1_csn  <= c_CSN_NONE;
            end
`ifdef AHB_SRAM_ERR_RESP_EN
            S_ERR1: begin
               r_state    <= S_ERR2;
               hready_out <= 1'b1;
               hresp      <= c_RESP_ERROR;
               sram_wen   <= 1'b1;
               bank0_csn  <= c_CSN_NONE;
               bank1_csn  <= c_CSN_NONE;
            end
            S_ERR2: begin
               r_state    <= S_IDLE;
               hready_out <= 1'b1;
               hresp      <= c_RESP_OKAY;
               sram_wen   <= 1'b1;
               bank0_csn  <= c_CSN_NONE;
               bank1_csn  <= c_CSN_NONE;
            end
`endif
            default: begin
               // IDLE, WR and RD2 all accept a new address phase.
               r_state    <= S_IDLE;
               hready_out <= 1'b1;
               hresp      <= c_RESP_OKAY;
               sram_wen   <= 1'b1;
               bank0_csn  <= c_CSN_NONE;
               bank1_csn  <= c_CSN_NONE;
               if (w_valid && !w_illegal) begin
                  if (hwrite) begin
                     r_state  <= S_WR;
                     sram_wen <= 1'b0;
                     if (haddr[15]) begin
                        bank1_csn <= w_lane_mask;
                     end else begin
                        bank0_csn <= w_lane_mask;
                     end
                  end else begin
                     r_state    <= S_RD1;
                     hready_out <= 1'b0;
                     if (haddr[15]) begin
                        bank1_csn <= c_CSN_ALL;
                     end else begin
                        bank0_csn <= c_CSN_ALL;
                     end
                  end
               end
`ifdef AHB_SRAM_ERR_RESP_EN
               else if (w_valid) begin
                  r_state    <= S_ERR1;
                  hready_out <= 1'b0;
                  hresp      <= c_RESP_ERROR;
               end
`endif
            end
         endcase
      end
   end

   assign sram_addr  = r_addr[14:2];
   assign bank_sel   = ~r_addr[15];
   assign sram_wdata = (r_state == S_WR) ? hwdata : '0;

   // SRAM read data is only meaningful in the cycle after the RD1 access.
   assign hrdata = (r_state != S_RD2) ? '0 :
                   bank_sel ? {sram_q3, sram_q2, sram_q1, sram_q0}
                            : {sram_q7, sram_q6, sram_q5, sram_q4};

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_if
// Brief    : Directed self-checking bench for ahb_sram_if with a behavioural
//            two-bank byte-lane SRAM. Honours AHB_SRAM_ERR_RESP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_if;

   localparam logic [1:0] c_IDLE   = 2'b00;
   localparam logic [1:0] c_BUSY   = 2'b01;
   localparam logic [1:0] c_NONSEQ = 2'b10;
   localparam logic [1:0] c_SEQ    = 2'b11;
   localparam logic [2:0] c_BYTE   = 3'd0;
   localparam logic [2:0] c_HALF   = 3'd1;
   localparam logic [2:0] c_WORD   = 3'd2;

   logic        hclk;
   logic        hreset;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hready_out;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic        sram_wen;
   logic [12:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        bank_sel;
   logic [3:0]  bank0_csn;
   logic [3:0]  bank1_csn;
   logic [7:0]  q [0:7];
   logic [7:0]  mem [0:65535];
   logic [31:0] obs_ctl;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] byte_data [0:3] = '{32'h0000_0011, 32'h0000_2200, 32'h0033_0000, 32'h4400_0000};
   logic [3:0]  byte_csn  [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   // Single-slave system: the global ready is this slave's ready.
   assign hready  = hready_out;
   assign obs_ctl = {20'd0, hready_out, hresp, sram_wen, bank0_csn, bank1_csn};

   ahb_sram_if u_dut (
      .hclk       (hclk),
      .hreset     (hreset),
      .hsel       (hsel),
      .haddr      (haddr),
      .htrans     (htrans),
      .hwrite     (hwrite),
      .hsize      (hsize),
      .hwdata     (hwdata),
      .hready     (hready),
      .hready_out (hready_out),
      .hresp      (hresp),
      .hrdata     (hrdata),
      .sram_q0    (q[0]),
      .sram_q1    (q[1]),
      .sram_q2    (q[2]),
      .sram_q3    (q[3]),
      .sram_q4    (q[4]),
      .sram_q5    (q[5]),
      .sram_q6    (q[6]),
      .sram_q7    (q[7]),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .bank_sel   (bank_sel),
      .bank0_csn  (bank0_csn),
      .bank1_csn  (bank1_csn)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   // Synchronous byte-lane SRAM: byte address = {bank, word address, lane}.
   always @(posedge hclk) begin
      for (int b = 0; b < 2; b++) begin
         for (int l = 0; l < 4; l++) begin
            if (((b == 0) ? bank0_csn[l] : bank1_csn[l]) == 1'b0) begin
               if (!sram_wen) begin
                  mem[{b[0], sram_addr, l[1:0]}] <= sram_wdata[8*l +: 8];
               end else begin
                  q[b*4+l] <= mem[{b[0], sram_addr, l[1:0]}];
               end
            end
         end
      end
   end

   function automatic logic [31:0] ctl(input logic rdy, input logic [1:0] resp, input logic wen,
                                      input logic [3:0] c0, input logic [3:0] c1);
      return {20'd0, rdy, resp, wen, c0, c1};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr);
      hsel   = sel;
      htrans = trans;
      hwrite = wr;
      hsize  = size;
      haddr  = addr;
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      hreset = 1'b0;
      hwdata = '0;
      drive(1'b0, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1 hreset = 1'b1;
      #2;
      check("reset_ctl",   obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
      check("reset_addr",  {19'd0, sram_addr}, 32'd0);
      check("reset_bank",  {31'd0, bank_sel}, 32'd1);
      check("reset_rdata", hrdata, 32'd0);
      check("reset_wdata", sram_wdata, 32'd0);
      #5 hreset = 1'b0;

      // Word write then read of 0x0010
      drive(1'b1, c_NONSEQ, 1'b1, c_WORD, 32'h0000_0010);
      tick();
      hwdata = 32'hDEAD_BEEF;
      drive(1'b1, c_NONSEQ, 1'b0, c_WORD, 32'h0000_0010);
      #1;
      check("wr_ctl",   obs_ctl, ctl(1'b1, 2'b00, 1'b0, 4'h0, 4'hF));
      check("wr_addr",  {19'd0, sram_addr}, 32'd4);
      check("wr_bank",  {31'd0, bank_sel}, 32'd1);
      check("wr_wdata", sram_wdata, 32'hDEAD_BEEF);
      check("wr_rdata", hrdata, 32'd0);
      tick();
      check("rd1_ctl",   obs_ctl, ctl(1'b0, 2'b00, 1'b1, 4'h0, 4'hF));
      check("rd1_wdata", sram_wdata, 32'd0);
      tick();
      drive(1'b1, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1;
      check("rd2_ctl",   obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
      check("rd2_rdata", hrdata, 32'hDEAD_BEEF);
      tick();
      check("post_rd_rdata", hrdata, 32'd0);

      // Pipelined byte writes to bank1, then word read
      drive(1'b1, c_NONSEQ, 1'b1, c_BYTE, 32'h0000_8020);
      tick();
      for (int i = 0; i < 4; i++) begin
         hwdata = byte_data[i];
         if (i < 3) drive(1'b1, c_SEQ, 1'b1, c_BYTE, 32'h0000_8021 + 32'(i));
         else       drive(1'b1, c_NONSEQ, 1'b0, c_WORD, 32'h0000_8020);
         #1;
         check($sformatf("byte%0d_ctl", i), obs_ctl, ctl(1'b1, 2'b00, 1'b0, 4'hF, byte_csn[i]));
         check($sformatf("byte%0d_bank", i), {31'd0, bank_sel}, 32'd0);
         check($sformatf("byte%0d_addr", i), {19'd0, sram_addr}, 32'd8);
         tick();
      end
      check("b1_rd1_ctl", obs_ctl, ctl(1'b0, 2'b00, 1'b1, 4'hF, 4'h0));
      tick();
      drive(1'b1, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1;
      check("b1_rd2_rdata", hrdata, 32'h4433_2211);
      tick();

      // Halfword write then immediate read of the containing word
      drive(1'b1, c_NONSEQ, 1'b1, c_HALF, 32'h0000_0006);
      tick();
      hwdata = 32'hABCD_0000;
      drive(1'b1, c_NONSEQ, 1'b0, c_WORD, 32'h0000_0004);
      #1;
      check("hw_ctl",  obs_ctl, ctl(1'b1, 2'b00, 1'b0, 4'b0011, 4'hF));
      check("hw_addr", {19'd0, sram_addr}, 32'd1);
      tick();
      check("hw_rd1_ready", {31'd0, hready_out}, 32'd0);
      tick();
      drive(1'b1, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1;
      check("hw_rd2_ready", {31'd0, hready_out}, 32'd1);
      check("hw_rd2_upper", {16'd0, hrdata[31:16]}, 32'h0000_ABCD);
      tick();

      // Misaligned word write
      drive(1'b1, c_NONSEQ, 1'b1, c_WORD, 32'h0000_0002);
      tick();
      hwdata = 32'h1234_5678;
      drive(1'b1, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1;
`ifdef AHB_SRAM_ERR_RESP_EN
      check("err1_ctl", obs_ctl, ctl(1'b0, 2'b01, 1'b1, 4'hF, 4'hF));
      tick();
      check("err2_ctl", obs_ctl, ctl(1'b1, 2'b01, 1'b1, 4'hF, 4'hF));
      tick();
      check("err_done_ctl", obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
`else
      check("illegal_ctl", obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
      check("illegal_wdata", sram_wdata, 32'd0);
      tick();
      check("illegal_next_ctl", obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
`endif

      // IDLE, BUSY and deselected transfers
      for (int i = 0; i < 10; i++) begin
         if (i < 3)      drive(1'b1, c_IDLE, 1'b1, c_WORD, 32'h0000_0010);
         else if (i < 5) drive(1'b1, c_BUSY, 1'b0, c_WORD, 32'h0000_0010);
         else            drive(1'b0, c_NONSEQ, 1'b0, c_WORD, 32'h0000_8010);
         tick();
         check($sformatf("idle%0d_ctl", i), obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
         check($sformatf("idle%0d_rdata", i), hrdata, 32'd0);
      end

      // Reset asserted while in RD1
      drive(1'b1, c_NONSEQ, 1'b0, c_WORD, 32'h0000_8020);
      tick();
      check("mid_rd1_ctl", obs_ctl, ctl(1'b0, 2'b00, 1'b1, 4'hF, 4'h0));
      hreset = 1'b1;
      #1;
      check("mid_rst_ctl",  obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
      check("mid_rst_addr", {19'd0, sram_addr}, 32'd0);
      check("mid_rst_bank", {31'd0, bank_sel}, 32'd1);
      drive(1'b1, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1 hreset = 1'b0;
      tick();
      check("post_rst_ctl",   obs_ctl, ctl(1'b1, 2'b00, 1'b1, 4'hF, 4'hF));
      check("post_rst_rdata", hrdata, 32'd0);

      // Normal read after the dropped transfer
      drive(1'b1, c_NONSEQ, 1'b0, c_WORD, 32'h0000_0010);
      tick();
      tick();
      drive(1'b1, c_IDLE, 1'b0, c_WORD, 32'h0);
      #1;
      check("final_rdata", hrdata, 32'hDEAD_BEEF);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ahb_sram_if.md
# ahb_sram_if

AHB-Lite slave front end for the two-bank, eight-byte-lane SRAM core. Decodes AHB address/control into bank select, per-byte active-low chip selects, word address, write enable and lane-aligned write data. Assembles read data from the eight SRAM byte outputs into `hrdata`. Sits directly upstream of the SRAM core, between the AHB interconnect and the core's SRAM-side inputs.

## Interface
- No parameters; the address map is fixed at 64 KiB (`haddr[15:0]` decoded).
- `hclk` in 1: bus clock; all state updates on its rising edge.
- `hreset` in 1: asynchronous, active-high reset.
- `hsel` in 1: slave select.
- `haddr` in 32: address; only bits [15:0] are used.
- `htrans` in 2: transfer type. NONSEQ and SEQ are valid; IDLE and BUSY are ignored.
- `hwrite` in 1: 1 means write.
- `hsize` in 3: 0 byte, 1 halfword, 2 word.
- `hwdata` in 32: write data, valid in the data phase.
- `hready` in 1: global ready; an address phase is accepted only when this is 1.
- `hready_out` out 1: slave ready.
- `hresp` out 2: 0 OKAY, 1 ERROR.
- `hrdata` out 32: read data.
- `sram_q0`..`sram_q7` in 8 each: byte outputs from the SRAM core (q0..q3 bank0, q4..q7 bank1).
- `sram_wen` out 1: active-low write enable.
- `sram_addr` out 13: word address, `haddr[14:2]`.
- `sram_wdata` out 32: write data.
- `bank_sel` out 1: 1 selects bank0 (`haddr[15]`=0); 0 selects bank1.
- `bank0_csn` out 4: active-low byte chip selects for bank0.
- `bank1_csn` out 4: active-low byte chip selects for bank1.

## Operation
- Valid transfer: `hsel & hready & htrans[1]` at a `hclk` edge. On a valid transfer the block registers addr[15:0], hwrite and hsize.
- Lane mask (active-low), from registered hsize and addr[1:0]:
  - byte: lane 0/1/2/3 gives 1110/1101/1011/0111.
  - halfword: addr[1]=0 gives 1100; addr[1]=1 gives 0011.
  - word: 0000.
- Chip selects: the unselected bank's csn is always 1111. Reads assert 0000 on the selected bank regardless of size.
- Illegal transfers: hsize>2, a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- FSM states: IDLE, WR, RD1, RD2, ERR1, ERR2.
  - IDLE / WR / RD2: a valid transfer moves to WR (write), RD1 (read), or ERR1 (illegal, macro on). Otherwise the FSM goes to IDLE.
  - WR: drives csn per the lane mask, `sram_wen`=0, `sram_wdata`=`hwdata`, `hready_out`=1.
  - RD1: drives selected csn=0000, `sram_wen`=1, `hready_out`=0. The next state is RD2.
  - RD2: drives `hready_out`=1. `hrdata` = {q3,q2,q1,q0} when bank_sel=1, else {q7,q6,q5,q4}. SRAM inputs are deasserted unless the next transfer is a write.
  - ERR1: `hready_out`=0, `hresp`=1, then ERR2.
  - ERR2: `hready_out`=1, `hresp`=1, then IDLE.
- IDLE outputs: all csn 1111, `sram_wen`=1, `hready_out`=1, `hresp`=0.
- `sram_addr` and `bank_sel` hold their last registered value between transfers.
- `hrdata`=0 outside RD2.

## Timing
- Reset values: state IDLE, `hready_out`=1, `hresp`=0, `hrdata`=0, `sram_wen`=1, `sram_addr`=0, `bank_sel`=1, `bank0_csn`=`bank1_csn`=1111, `sram_wdata`=0.
- Write: address phase at edge N. Data phase is cycle N..N+1 with zero wait states; the SRAM captures at the end of that cycle.
- Read: address phase at edge N. RD1 is one wait state; `hrdata` is valid in RD2 (cycle N+1..N+2), sampled by the master at edge N+2. The next address phase is held off during RD1.
- Back-to-back transfers: a write followed by a read of the same word returns the new data. A read followed by a write incurs no extra cycles beyond RD1.
- A non-valid `htrans` (IDLE/BUSY) or `hsel`=0 gets a zero-wait OKAY with no SRAM access.
- Reset asserted mid-transfer: all outputs take reset values immediately (asynchronously), and the in-flight transfer is dropped.

## Configuration
- `AHB_SRAM_ERR_RESP_EN`
  - Defined: illegal transfers take the two-cycle ERROR response (ERR1 then ERR2) with no SRAM access.
  - Undefined: illegal transfers are treated as IDLE. They get a zero-wait OKAY, no csn is asserted, `hrdata`=0, and ERR1/ERR2 are not synthesized.

## Test plan
- Reset value check: assert `hreset` mid-read (in RD1) → all outputs at reset values in the same cycle; the FSM is IDLE after release.
- Word write then read: word write 0xDEADBEEF at 0x0010, then read 0x0010 → write data phase shows `bank_sel`=1, `bank0_csn`=0000, `sram_addr`=4; read returns 0xDEADBEEF after one wait state.
- Byte writes to bank1: four byte writes 0x11, 0x22, 0x33, 0x44 at 0x8020..0x8023 → `bank1_csn` 1110/1101/1011/0111, `bank0_csn`=1111; a word read of 0x8020 returns 0x44332211.
- Halfword and pipelining: halfword write 0xABCD at 0x0006 → `bank0_csn`=0011. An immediately following read of 0x0004 returns 0xABCDxxxx in the upper half, with `hready_out` low for exactly one cycle.
- Illegal transfer, macro on: word write at 0x0002 → ERROR for two cycles (`hready_out` 0 then 1), no csn asserted.
- Illegal transfer, macro off: the same stimulus → zero-wait OKAY with no csn asserted.
- Idle and deselect: `htrans`=IDLE or `hsel`=0 for 10 cycles → csn stay 1111, `hready_out`=1, `hresp`=0.
